// File: rtl/a_config_cmd_tx.sv
// Configuration command transmitter: snapshots a configuration set on start,
// streams it as 39 command words into a FIFO, then waits for an acknowledge
// word from the response FIFO with a bounded timeout.
module a_config_cmd_tx #(
  parameter int unsigned ACK_TIMEOUT = 65535
) (
  input  logic         clk_a_domain,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   cfg_asic_mode,
  input  logic [15:0]  cfg_training_epochs,
  input  logic [15:0]  cfg_inference_epochs,
  input  logic [1:0]   cfg_dataset,
  input  logic [15:0]  cfg_timesteps,
  input  logic [15:0]  cfg_input_size_layer1,
  input  logic         cfg_long_time_streaming,
  input  logic         cfg_binary_classifier,
  input  logic         cfg_loser_encourage,
  input  logic [254:0] cfg_layer1_cut_list,
  input  logic [239:0] cfg_layer2_cut_list,
  output logic         cmd_wr_en,
  output logic [31:0]  cmd_din,
  input  logic         cmd_full,
  output logic         rsp_rd_en,
  input  logic [31:0]  rsp_dout,
  input  logic         rsp_valid,
  output logic         busy,
  output logic         done,
  output logic         ack_timeout_err,
  output logic         bad_rsp
);

  localparam logic [31:0] LastWait = 32'(ACK_TIMEOUT - 1);
  localparam logic [5:0]  LastIdx  = 6'd38;

  typedef enum logic [1:0] {StIdle, StSend, StWaitAck} state_e;

  state_e       state_q, state_d;
  logic [5:0]   idx_q, idx_d;
  logic [31:0]  wait_cnt_q, wait_cnt_d;
  logic         done_q, done_d;
  logic         timeout_err_q, timeout_err_d;
  logic         bad_rsp_q, bad_rsp_d;
  logic         accept;
  logic         is_ack;

  logic [1:0]   asic_mode_q;
  logic [15:0]  training_epochs_q;
  logic [15:0]  inference_epochs_q;
  logic [1:0]   dataset_q;
  logic [15:0]  timesteps_q;
  logic [15:0]  input_size_layer1_q;
  logic         long_time_streaming_q;
  logic         binary_classifier_q;
  logic         loser_encourage_q;
  logic [254:0] layer1_cut_q;
  logic [239:0] layer2_cut_q;

  logic [16:0]  payload;
  logic [7:0]   l1_base;
  logic [7:0]   l2_base;

  // FIFO strobes are gated by reset so an abort never writes or pops a word.
  assign cmd_wr_en = reset_n && (state_q == StSend) && !cmd_full;
  assign rsp_rd_en = reset_n && (state_q == StWaitAck) && rsp_valid;
  assign is_ack    = rsp_rd_en && (rsp_dout[14:0] == 15'd2);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign ack_timeout_err = timeout_err_q;
  assign bad_rsp   = bad_rsp_q;

  // Payload selection for the word at the current index.
  always_comb begin
    payload = '0;
    l1_base = 8'(idx_q - 6'd9) * 8'd17;
    l2_base = 8'(idx_q - 6'd24) * 8'd16;
    if (idx_q >= 6'd24) begin
      payload = {1'b0, layer2_cut_q[l2_base +: 16]};
    end else if (idx_q >= 6'd9) begin
      payload = layer1_cut_q[l1_base +: 17];
    end else begin
      case (idx_q)
        6'd0:    payload = {15'd0, asic_mode_q};
        6'd1:    payload = {1'b0, training_epochs_q};
        6'd2:    payload = {1'b0, inference_epochs_q};
        6'd3:    payload = {15'd0, dataset_q};
        6'd4:    payload = {1'b0, timesteps_q};
        6'd5:    payload = {1'b0, input_size_layer1_q};
        6'd6:    payload = {16'd0, long_time_streaming_q};
        6'd7:    payload = {16'd0, binary_classifier_q};
        6'd8:    payload = {16'd0, loser_encourage_q};
        default: payload = '0;
      endcase
    end
    cmd_din = (state_q == StSend) ? {payload, 15'd1} : 32'd0;
  end

  // Next-state logic for the FSM, word index, wait counter and status flags.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_cnt_d    = wait_cnt_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    bad_rsp_d     = bad_rsp_q;
    accept        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept        = 1'b1;
          idx_d         = '0;
          timeout_err_d = 1'b0;
          bad_rsp_d     = 1'b0;
          state_d       = StSend;
        end
      end
      StSend: begin
        if (cmd_wr_en) begin
          if (idx_q == LastIdx) begin
            idx_d      = '0;
            wait_cnt_d = '0;
            state_d    = StWaitAck;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      StWaitAck: begin
        // An acknowledge wins over a timeout landing in the same cycle.
        if (is_ack) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          if (rsp_rd_en) bad_rsp_d = 1'b1;
          if (wait_cnt_q == LastWait) begin
            timeout_err_d = 1'b1;
            state_d       = StIdle;
          end else begin
            wait_cnt_d = wait_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk_a_domain) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      wait_cnt_q    <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      bad_rsp_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_cnt_q    <= wait_cnt_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      bad_rsp_q     <= bad_rsp_d;
    end
  end

  // Configuration snapshot, captured only when a start is accepted.
  always_ff @(posedge clk_a_domain) begin
    if (!reset_n) begin
      asic_mode_q           <= '0;
      training_epochs_q     <= '0;
      inference_epochs_q    <= '0;
      dataset_q             <= '0;
      timesteps_q           <= '0;
      input_size_layer1_q   <= '0;
      long_time_streaming_q <= 1'b0;
      binary_classifier_q   <= 1'b0;
      loser_encourage_q     <= 1'b0;
      layer1_cut_q          <= '0;
      layer2_cut_q          <= '0;
    end else if (accept) begin
      asic_mode_q           <= cfg_asic_mode;
      training_epochs_q     <= cfg_training_epochs;
      inference_epochs_q    <= cfg_inference_epochs;
      dataset_q             <= cfg_dataset;
      timesteps_q           <= cfg_timesteps;
      input_size_layer1_q   <= cfg_input_size_layer1;
      long_time_streaming_q <= cfg_long_time_streaming;
      binary_classifier_q   <= cfg_binary_classifier;
      loser_encourage_q     <= cfg_loser_encourage;
      layer1_cut_q          <= cfg_layer1_cut_list;
      layer2_cut_q          <= cfg_layer2_cut_list;
    end
  end

endmodule

// File: tb/tb_a_config_cmd_tx.sv
// Self-checking bench for a_config_cmd_tx: table-driven and random transactions
// compared against a word-list and timing model derived from the command rules.
module tb_a_config_cmd_tx;

  localparam int AckT = 100;

  logic         clk_a_domain = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   cfg_asic_mode;
  logic [15:0]  cfg_training_epochs;
  logic [15:0]  cfg_inference_epochs;
  logic [1:0]   cfg_dataset;
  logic [15:0]  cfg_timesteps;
  logic [15:0]  cfg_input_size_layer1;
  logic         cfg_long_time_streaming;
  logic         cfg_binary_classifier;
  logic         cfg_loser_encourage;
  logic [254:0] cfg_layer1_cut_list;
  logic [239:0] cfg_layer2_cut_list;
  logic         cmd_wr_en;
  logic [31:0]  cmd_din;
  logic         cmd_full;
  logic         rsp_rd_en;
  logic [31:0]  rsp_dout;
  logic         rsp_valid;
  logic         busy;
  logic         done;
  logic         ack_timeout_err;
  logic         bad_rsp;

  a_config_cmd_tx #(.ACK_TIMEOUT(AckT)) dut (
    .clk_a_domain            (clk_a_domain),
    .reset_n                 (reset_n),
    .start                   (start),
    .cfg_asic_mode           (cfg_asic_mode),
    .cfg_training_epochs     (cfg_training_epochs),
    .cfg_inference_epochs    (cfg_inference_epochs),
    .cfg_dataset             (cfg_dataset),
    .cfg_timesteps           (cfg_timesteps),
    .cfg_input_size_layer1   (cfg_input_size_layer1),
    .cfg_long_time_streaming (cfg_long_time_streaming),
    .cfg_binary_classifier   (cfg_binary_classifier),
    .cfg_loser_encourage     (cfg_loser_encourage),
    .cfg_layer1_cut_list     (cfg_layer1_cut_list),
    .cfg_layer2_cut_list     (cfg_layer2_cut_list),
    .cmd_wr_en               (cmd_wr_en),
    .cmd_din                 (cmd_din),
    .cmd_full                (cmd_full),
    .rsp_rd_en               (rsp_rd_en),
    .rsp_dout                (rsp_dout),
    .rsp_valid               (rsp_valid),
    .busy                    (busy),
    .done                    (done),
    .ack_timeout_err         (ack_timeout_err),
    .bad_rsp                 (bad_rsp)
  );

  always #5 clk_a_domain = ~clk_a_domain;

  typedef struct {
    int stall_at;
    int stall_len;
    bit rnd_full;
    int rsp_delay;
    int n_bad;
    bit has_ack;
    bit exp_done;
    bit exp_bad;
    bit exp_to;
  } vec_t;

  int total = 0;
  int n_fail = 0;

  logic [31:0] got_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] exp_w[39];

  logic        s_wr, s_rd, s_valid, s_busy, s_done, s_err, s_bad;
  logic [31:0] s_din;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [16:0] p);
    return (32'(p) << 15) | 32'd1;
  endfunction

  // Expected 39-word stream for the cfg currently on the inputs.
  function automatic void build_words();
    logic [254:0] t1;
    logic [239:0] t2;
    exp_w[0] = word_of(17'(cfg_asic_mode));
    exp_w[1] = word_of(17'(cfg_training_epochs));
    exp_w[2] = word_of(17'(cfg_inference_epochs));
    exp_w[3] = word_of(17'(cfg_dataset));
    exp_w[4] = word_of(17'(cfg_timesteps));
    exp_w[5] = word_of(17'(cfg_input_size_layer1));
    exp_w[6] = word_of(17'(cfg_long_time_streaming));
    exp_w[7] = word_of(17'(cfg_binary_classifier));
    exp_w[8] = word_of(17'(cfg_loser_encourage));
    for (int i = 0; i < 15; i++) begin
      t1 = cfg_layer1_cut_list >> (17 * i);
      t2 = cfg_layer2_cut_list >> (16 * i);
      exp_w[9 + i]  = word_of(t1[16:0]);
      exp_w[24 + i] = word_of({1'b0, t2[15:0]});
    end
  endfunction

  // Response-phase outcome from the acknowledge/timeout rules.
  function automatic void model(input vec_t v, output int done_at, output int idle_at,
                                output bit e_done, output bit e_bad, output bit e_to);
    int  ack_k;
    bit  ack_ok;
    ack_k   = v.rsp_delay + v.n_bad;
    ack_ok  = v.has_ack && (ack_k <= AckT - 1);
    e_done  = ack_ok;
    e_to    = !ack_ok;
    e_bad   = (v.n_bad > 0) && (v.rsp_delay <= AckT - 1);
    done_at = ack_ok ? ack_k + 1 : -1;
    idle_at = ack_ok ? ack_k + 1 : AckT;
  endfunction

  task automatic rand_cfg();
    logic [255:0] t;
    cfg_asic_mode           = 2'($urandom);
    cfg_training_epochs     = 16'($urandom);
    cfg_inference_epochs    = 16'($urandom);
    cfg_dataset             = 2'($urandom);
    cfg_timesteps           = 16'($urandom);
    cfg_input_size_layer1   = 16'($urandom);
    cfg_long_time_streaming = 1'($urandom);
    cfg_binary_classifier   = 1'($urandom);
    cfg_loser_encourage     = 1'($urandom);
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    cfg_layer1_cut_list = t[254:0];
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    cfg_layer2_cut_list = t[239:0];
  endtask

  // First-word-fall-through response FIFO; data is junk while empty.
  task automatic refresh_rsp();
    rsp_valid = (rsp_q.size() > 0);
    rsp_dout  = rsp_valid ? rsp_q[0] : $urandom;
  endtask

  // Sample outputs mid-cycle, then advance to just past the next rising edge.
  task automatic tick();
    @(negedge clk_a_domain);
    s_wr = cmd_wr_en; s_din = cmd_din; s_rd = rsp_rd_en; s_valid = rsp_valid;
    s_busy = busy; s_done = done; s_err = ack_timeout_err; s_bad = bad_rsp;
    if (s_wr) got_q.push_back(s_din);
    @(posedge clk_a_domain);
    #1;
    if (s_rd && s_valid && rsp_q.size() > 0) void'(rsp_q.pop_front());
    refresh_rsp();
  endtask

  task automatic run_txn(input vec_t v, input bit keep_cfg);
    int cyc, n, n_full, stall_left;
    int din_bad, full_bad, gap_bad, busy_bad, word_bad, wr_bad, rd_bad;
    int done_at, idle_at, done_cnt, e_done_at, e_idle_at;
    bit e_done, e_bad, e_to;
    logic [31:0] w;
    din_bad = 0; full_bad = 0; gap_bad = 0; busy_bad = 0; word_bad = 0;
    wr_bad = 0; rd_bad = 0; n_full = 0;
    if (!keep_cfg) rand_cfg();
    build_words();
    cmd_full = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    got_q.delete();
    cyc = 0;
    stall_left = v.stall_len;
    while (got_q.size() < 39 && cyc < 39 + v.stall_len + 80) begin
      cyc++;
      rand_cfg();
      start = ($urandom_range(0, 7) == 0);
      cmd_full = 1'b0;
      if (got_q.size() == v.stall_at && stall_left > 0) begin
        cmd_full = 1'b1;
        stall_left--;
      end else if (v.rnd_full && $urandom_range(0, 3) == 0) begin
        cmd_full = 1'b1;
      end
      if (cmd_full) n_full++;
      n = got_q.size();
      tick();
      if (cyc == 1) chk("sticky_clear", {s_done, s_err, s_bad}, 3'b000);
      if (s_din !== exp_w[n]) din_bad++;
      if (cmd_full && s_wr) full_bad++;
      if (!cmd_full && !s_wr) gap_bad++;
      if (!s_busy) busy_bad++;
    end
    start = 1'b0;
    chk("n_writes", got_q.size(), 39);
    chk("last_write_cycle", cyc, 39 + n_full);
    for (int i = 0; i < 39 && i < got_q.size(); i++) if (got_q[i] !== exp_w[i]) word_bad++;
    chk("word_mismatches", word_bad, 0);
    chk("din_hold", din_bad, 0);
    chk("write_while_full", full_bad, 0);
    chk("missed_write", gap_bad, 0);
    chk("busy_in_send", busy_bad, 0);

    model(v, e_done_at, e_idle_at, e_done, e_bad, e_to);
    done_at = -1; idle_at = -1; done_cnt = 0;
    for (int rel = 0; rel <= AckT + 5; rel++) begin
      cmd_full = 1'($urandom);
      if (rel == v.rsp_delay) begin
        for (int i = 0; i < v.n_bad; i++) begin
          w = (i == 0) ? 32'h5 : $urandom;
          if (w[14:0] == 15'd2) w[0] = ~w[0];
          rsp_q.push_back(w);
        end
        if (v.has_ack) begin
          w = $urandom;
          w[14:0] = 15'd2;
          rsp_q.push_back(w);
        end
        refresh_rsp();
      end
      tick();
      if (s_done) begin
        done_cnt++;
        if (done_at < 0) done_at = rel;
      end
      if (!s_busy && idle_at < 0) idle_at = rel;
      if (s_wr) wr_bad++;
      if (s_busy ? (s_rd !== s_valid) : (s_rd !== 1'b0)) rd_bad++;
    end
    rsp_q.delete();
    refresh_rsp();
    cmd_full = 1'b0;
    chk("write_after_send", wr_bad, 0);
    chk("rd_en_rule", rd_bad, 0);
    chk("done_cycle", done_at, e_done_at);
    chk("idle_cycle", idle_at, e_idle_at);
    chk("done_pulses", done_cnt, e_done ? 1 : 0);
    chk("done_expected", done_cnt > 0, v.exp_done);
    chk("bad_rsp", s_bad, v.exp_bad);
    chk("ack_timeout_err", s_err, v.exp_to);
  endtask

  task automatic rand_vec(output vec_t v);
    int d, ia;
    v.stall_at  = $urandom_range(0, 38);
    v.stall_len = $urandom_range(0, 4);
    v.rnd_full  = 1'($urandom);
    v.rsp_delay = $urandom_range(0, 105);
    v.n_bad     = $urandom_range(0, 3);
    v.has_ack   = 1'($urandom);
    model(v, d, ia, v.exp_done, v.exp_bad, v.exp_to);
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;
    int   cyc;
    //             stall  len rnd delay bad ack  done bad to
    tbl[0] = '{0,  0, 0, 0,   0, 1, 1, 0, 0};
    tbl[1] = '{10, 5, 0, 3,   0, 1, 1, 0, 0};
    tbl[2] = '{0,  0, 0, 2,   1, 1, 1, 1, 0};
    tbl[3] = '{0,  0, 0, 0,   0, 0, 0, 0, 1};
    tbl[4] = '{38, 3, 0, 5,   2, 1, 1, 1, 0};
    tbl[5] = '{0,  0, 0, 99,  0, 1, 1, 0, 0};
    tbl[6] = '{0,  0, 0, 100, 0, 1, 0, 0, 1};
    tbl[7] = '{0,  0, 1, 10,  1, 0, 0, 1, 1};
    tbl[8] = '{20, 2, 1, 97,  2, 1, 1, 1, 0};
    tbl[9] = '{1,  1, 0, 0,   3, 1, 1, 1, 0};

    reset_n = 1'b0;
    start = 1'b0;
    cmd_full = 1'b0;
    rand_cfg();
    refresh_rsp();
    repeat (3) tick();
    chk("reset_outputs", {s_busy, s_done, s_err, s_bad, s_wr, s_rd}, 6'b0);
    chk("reset_din", s_din, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", {s_busy, s_done, s_wr}, 3'b0);

    // Known-value stream.
    rand_cfg();
    cfg_asic_mode = 2'd2;
    cfg_training_epochs = 16'h1234;
    cfg_layer1_cut_list[16:0] = 17'h1FFFF;
    run_txn(tbl[0], 1'b1);
    chk("word0", got_q.size() > 0 ? got_q[0] : 32'hx, 32'h0001_0001);
    chk("word1", got_q.size() > 1 ? got_q[1] : 32'hx, 32'h091A_0001);
    chk("word9", got_q.size() > 9 ? got_q[9] : 32'hx, 32'hFFFF_8001);

    for (int i = 0; i < 10; i++) run_txn(tbl[i], 1'b0);

    // Reset in the middle of SEND, then a fresh transaction.
    rand_cfg();
    start = 1'b1;
    tick();
    start = 1'b0;
    got_q.delete();
    cyc = 0;
    while (got_q.size() < 20 && cyc < 60) begin
      cyc++;
      tick();
    end
    chk("pre_reset_writes", got_q.size(), 20);
    reset_n = 1'b0;
    repeat (3) tick();
    chk("no_write_in_reset", got_q.size(), 20);
    chk("reset_mid_flags", {s_busy, s_done, s_err, s_bad, s_wr}, 5'b0);
    reset_n = 1'b1;
    tick();
    chk("idle_after_abort", {s_busy, s_wr}, 2'b0);
    rand_vec(v);
    run_txn(v, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rand_vec(v);
      run_txn(v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, n_fail);
    $finish;
  end

endmodule
